// File: rtl/mem_stage_ls_pkg.sv
// Shared definitions for the memory stage: bus widths, EX->MS bus field offsets,
// load_op encodings and the MS->WB bus layout.
package mem_stage_ls_pkg;

    localparam int ES_BUS_W = 74;
    localparam int MS_BUS_W = 70;

    // EX->MS bus field positions
    localparam int HAS_REQ_BIT = 73;
    localparam int LOAD_OP_HI  = 72;
    localparam int LOAD_OP_LO  = 70;
    localparam int GR_WE_BIT   = 69;
    localparam int DEST_HI     = 68;
    localparam int DEST_LO     = 64;
    localparam int RESULT_HI   = 63;
    localparam int RESULT_LO   = 32;
    localparam int PC_HI       = 31;
    localparam int PC_LO       = 0;

    typedef enum logic [2:0] {
        LOAD_NONE = 3'd0,
        LOAD_LB   = 3'd1,
        LOAD_LBU  = 3'd2,
        LOAD_LH   = 3'd3,
        LOAD_LHU  = 3'd4,
        LOAD_LW   = 3'd5
    } load_op_e;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_bus_t;

    // Codes 6 and 7 are treated as "no load".
    function automatic logic op_is_load(input logic [2:0] op);
        return (op >= LOAD_LB) && (op <= LOAD_LW);
    endfunction

endpackage

// File: rtl/mem_stage_ls_load_align.sv
// Byte/half lane selection and sign/zero extension of raw SRAM read data.
module load_align
    import mem_stage_ls_pkg::*;
(
    input  logic [2:0]  load_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = rdata[7:0];
        case (addr)
            2'd0: byte_lane = rdata[7:0];
            2'd1: byte_lane = rdata[15:8];
            2'd2: byte_lane = rdata[23:16];
            2'd3: byte_lane = rdata[31:24];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = 32'd0;
        case (load_op)
            LOAD_LB:  data = {{24{byte_lane[7]}}, byte_lane};
            LOAD_LBU: data = {24'd0, byte_lane};
            LOAD_LH:  data = {{16{half_lane[15]}}, half_lane};
            LOAD_LHU: data = {16'd0, half_lane};
            LOAD_LW:  data = rdata;
            default:  data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_stage_ls.sv
// Memory pipeline stage: waits for the data SRAM response, aligns load data,
// buffers early responses and drops responses that belong to flushed requests.
module mem_stage_ls
    import mem_stage_ls_pkg::*;
#(
    parameter int SRAM_MODE = 0,
    parameter int DISCARD_W = 2,
    parameter int FWD_EN    = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                ws_allowin,
    output logic                ms_allowin,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    output logic                ms_to_ws_valid,
    output logic [MS_BUS_W-1:0] ms_to_ws_bus,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    output logic                ms_fwd_valid,
    output logic [4:0]          ms_fwd_dest,
    output logic                ms_fwd_ready,
    output logic [31:0]         ms_fwd_data
);

    localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;
    localparam logic [DISCARD_W-1:0] DISCARD_ONE = DISCARD_W'(1);

    logic [ES_BUS_W-1:0]  ms_bus_r;
    logic                 ms_valid;
    logic                 resp_buf_valid;
    logic [31:0]          resp_buf;
    logic [DISCARD_W-1:0] discard_cnt;

    logic        has_req;
    logic [2:0]  load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic        ms_ready_go;
    logic        data_ok_acc;
    logic        discard_hit;
    logic        buf_capture;
    logic        flush_pending;
    logic [31:0] load_rdata;
    logic [31:0] aligned_data;
    logic [31:0] final_result;
    logic        fwd_valid_raw;
    ms_bus_t     out_bus;

    assign has_req    = ms_bus_r[HAS_REQ_BIT];
    assign load_op    = ms_bus_r[LOAD_OP_HI:LOAD_OP_LO];
    assign gr_we      = ms_bus_r[GR_WE_BIT];
    assign dest       = ms_bus_r[DEST_HI:DEST_LO];
    assign alu_result = ms_bus_r[RESULT_HI:RESULT_LO];
    assign pc         = ms_bus_r[PC_HI:PC_LO];

    // A response is owed to a flushed request while discard_cnt is nonzero,
    // so the held instruction only sees data_ok once the counter drains.
    always_comb begin
        discard_hit = 1'b0;
        data_ok_acc = 1'b0;
        if (SRAM_MODE == 1) begin
            discard_hit = data_sram_data_ok && (discard_cnt != '0);
            data_ok_acc = data_sram_data_ok && (discard_cnt == '0) && ms_valid
                          && has_req && !resp_buf_valid;
        end
    end

    always_comb begin
        ms_ready_go = 1'b1;
        if (has_req && (SRAM_MODE == 1)) begin
            ms_ready_go = data_ok_acc || resp_buf_valid;
        end
    end

    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;
    assign buf_capture    = data_ok_acc && !ws_allowin;
    assign flush_pending  = (SRAM_MODE == 1) && flush && ms_valid && has_req
                            && !resp_buf_valid && !data_ok_acc;

    assign load_rdata = resp_buf_valid ? resp_buf : data_sram_rdata;

    load_align u_load_align (
        .load_op (load_op),
        .addr    (alu_result[1:0]),
        .rdata   (load_rdata),
        .data    (aligned_data)
    );

    assign final_result = op_is_load(load_op) ? aligned_data : alu_result;

    always_comb begin
        out_bus              = '0;
        out_bus.gr_we        = gr_we;
        out_bus.dest         = dest;
        out_bus.final_result = final_result;
        out_bus.pc           = pc;
    end
    assign ms_to_ws_bus = out_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid <= 1'b0;
        end else if (flush) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    // Payload registers carry no reset; they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin) begin
            ms_bus_r <= es_to_ms_bus;
        end
        if (buf_capture) begin
            resp_buf <= data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_buf_valid <= 1'b0;
        end else if (flush || ms_allowin) begin
            resp_buf_valid <= 1'b0;
        end else if (buf_capture) begin
            resp_buf_valid <= 1'b1;
        end
    end

    // A flush and a discarded response in the same cycle cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (flush_pending && !discard_hit) begin
            if (discard_cnt != DISCARD_MAX) begin
                discard_cnt <= discard_cnt + DISCARD_ONE;
            end
        end else if (discard_hit && !flush_pending) begin
            discard_cnt <= discard_cnt - DISCARD_ONE;
        end
    end

    assign fwd_valid_raw = ms_valid && gr_we && (dest != 5'd0);

    assign ms_fwd_valid = (FWD_EN != 0) && fwd_valid_raw;
    assign ms_fwd_ready = (FWD_EN != 0) && fwd_valid_raw
                          && (!op_is_load(load_op) || ms_ready_go);
    assign ms_fwd_dest  = (FWD_EN != 0) ? dest : 5'd0;
    assign ms_fwd_data  = (FWD_EN != 0) ? final_result : 32'd0;

endmodule

// File: tb/tb_mem_stage_ls.sv
// Self-checking bench for mem_stage_ls: one fixed-latency and one handshake
// instance share stimulus; each scenario checks the instance it targets.
module tb_mem_stage_ls;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        ws_allowin;
    logic        es_to_ms_valid;
    logic [73:0] es_to_ms_bus;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic        m0_allowin, m0_to_ws_valid, m0_fwd_valid, m0_fwd_ready;
    logic [69:0] m0_to_ws_bus;
    logic [4:0]  m0_fwd_dest;
    logic [31:0] m0_fwd_data;
    logic        m1_allowin, m1_to_ws_valid, m1_fwd_valid, m1_fwd_ready;
    logic [69:0] m1_to_ws_bus;
    logic [4:0]  m1_fwd_dest;
    logic [31:0] m1_fwd_data;

    int checks;
    int failures;

    mem_stage_ls #(.SRAM_MODE(0), .DISCARD_W(2), .FWD_EN(1)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .ws_allowin(ws_allowin),
        .ms_allowin(m0_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_to_ms_bus(es_to_ms_bus), .ms_to_ws_valid(m0_to_ws_valid),
        .ms_to_ws_bus(m0_to_ws_bus), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ms_fwd_valid(m0_fwd_valid),
        .ms_fwd_dest(m0_fwd_dest), .ms_fwd_ready(m0_fwd_ready),
        .ms_fwd_data(m0_fwd_data)
    );

    mem_stage_ls #(.SRAM_MODE(1), .DISCARD_W(2), .FWD_EN(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .ws_allowin(ws_allowin),
        .ms_allowin(m1_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_to_ms_bus(es_to_ms_bus), .ms_to_ws_valid(m1_to_ws_valid),
        .ms_to_ws_bus(m1_to_ws_bus), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ms_fwd_valid(m1_fwd_valid),
        .ms_fwd_dest(m1_fwd_dest), .ms_fwd_ready(m1_fwd_ready),
        .ms_fwd_data(m1_fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [73:0] make_bus(logic hr, logic [2:0] op, logic we,
                                             logic [4:0] d, logic [31:0] alu, logic [31:0] pc);
        return {hr, op, we, d, alu, pc};
    endfunction

    function automatic logic ref_is_load(logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd5);
    endfunction

    // Reference alignment by shifting and two's-complement arithmetic.
    function automatic logic [31:0] ref_final(logic [2:0] op, logic [31:0] alu, logic [31:0] rd);
        int unsigned b;
        int unsigned h;
        b = (rd >> (8 * int'(alu[1:0]))) & 32'hFF;
        h = (rd >> (16 * int'(alu[1]))) & 32'hFFFF;
        case (op)
            3'd1:    return (b >= 128) ? b - 256 : b;
            3'd2:    return b;
            3'd3:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return h;
            3'd5:    return rd;
            default: return alu;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush             = 1'b0;
        ws_allowin        = 1'b1;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        idle_inputs();
        flush          = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(1'b1, 3'd5, 1'b1, 5'd5, 32'h100, 32'h40);
        step();
        flush = 1'b0;
        step();
        @(negedge clk);
        checks++; if (m0_to_ws_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid0 got=%b exp=0", m0_to_ws_valid); end
        checks++; if (m0_allowin !== 1'b1) begin failures++; $display("[TB] FAIL reset_allowin0 got=%b exp=1", m0_allowin); end
        checks++; if (m1_to_ws_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid1 got=%b exp=0", m1_to_ws_valid); end
        checks++; if (m1_allowin !== 1'b1) begin failures++; $display("[TB] FAIL reset_allowin1 got=%b exp=1", m1_allowin); end
        checks++; if ({m0_fwd_valid, m0_fwd_ready, m1_fwd_valid, m1_fwd_ready} !== 4'b0) begin
            failures++; $display("[TB] FAIL reset_fwd got=%b exp=0000", {m0_fwd_valid, m0_fwd_ready, m1_fwd_valid, m1_fwd_ready});
        end
        reset          = 1'b0;
        es_to_ms_valid = 1'b0;
        step();
        @(negedge clk);
        checks++; if (m1_allowin !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_allowin got=%b exp=1", m1_allowin); end
    endtask

    task automatic test_load_align();
        logic [2:0]  ops  [23];
        logic [31:0] alus [23];
        logic [31:0] rds  [23];
        logic [31:0] exps [23];
        logic        we;
        logic [4:0]  d;
        logic [31:0] pc;
        logic [69:0] exp_bus;
        logic        exp_fv;
        do_reset();
        ops[0] = 3'd1; alus[0] = 32'h0000_1003; rds[0] = 32'h80FF_1234; exps[0] = 32'hFFFF_FF80;
        ops[1] = 3'd4; alus[1] = 32'h0000_2002; rds[1] = 32'hBEEF_0000; exps[1] = 32'h0000_BEEF;
        ops[2] = 3'd3; alus[2] = 32'h0000_2002; rds[2] = 32'hBEEF_0000; exps[2] = 32'hFFFF_BEEF;
        for (int i = 3; i < 23; i++) begin
            ops[i]  = 3'($urandom_range(0, 7));
            alus[i] = $urandom;
            rds[i]  = $urandom;
            exps[i] = ref_final(ops[i], alus[i], rds[i]);
        end
        for (int i = 0; i < 23; i++) begin
            we = 1'($urandom_range(0, 1));
            d  = 5'($urandom_range(0, 31));
            pc = $urandom;
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = make_bus(ref_is_load(ops[i]), ops[i], we, d, alus[i], pc);
            step();
            es_to_ms_valid  = 1'b0;
            data_sram_rdata = rds[i];
            @(negedge clk);
            exp_bus = {we, d, exps[i], pc};
            exp_fv  = we && (d != 5'd0);
            checks++; if (m0_to_ws_valid !== 1'b1) begin failures++; $display("[TB] FAIL align_valid[%0d] got=%b exp=1", i, m0_to_ws_valid); end
            checks++; if (m0_to_ws_bus !== exp_bus) begin failures++; $display("[TB] FAIL align_bus[%0d] op=%0d got=%h exp=%h", i, ops[i], m0_to_ws_bus, exp_bus); end
            checks++; if (m0_fwd_valid !== exp_fv || m0_fwd_ready !== exp_fv) begin
                failures++; $display("[TB] FAIL align_fwd[%0d] got=%b%b exp=%b%b", i, m0_fwd_valid, m0_fwd_ready, exp_fv, exp_fv);
            end
            if (exp_fv) begin
                checks++; if (m0_fwd_data !== exps[i]) begin failures++; $display("[TB] FAIL align_fwd_data[%0d] got=%h exp=%h", i, m0_fwd_data, exps[i]); end
            end
            step();
            @(negedge clk);
            checks++; if (m0_to_ws_valid !== 1'b0) begin failures++; $display("[TB] FAIL align_one_cycle[%0d] got=%b exp=0", i, m0_to_ws_valid); end
        end
    endtask

    task automatic test_forwarding();
        logic [4:0] dests [2];
        dests[0] = 5'd0;
        dests[1] = 5'd5;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = make_bus(1'b0, 3'd0, 1'b1, dests[i], 32'hCAFE_0000 + i, 32'h200);
            step();
            es_to_ms_valid = 1'b0;
            @(negedge clk);
            checks++; if (m0_fwd_valid !== (i == 1)) begin failures++; $display("[TB] FAIL fwd_valid_dest%0d got=%b exp=%b", dests[i], m0_fwd_valid, (i == 1)); end
            checks++; if (m1_fwd_ready !== (i == 1)) begin failures++; $display("[TB] FAIL fwd_ready_dest%0d got=%b exp=%b", dests[i], m1_fwd_ready, (i == 1)); end
            if (i == 1) begin
                checks++; if (m0_fwd_data !== 32'hCAFE_0001 || m0_fwd_dest !== 5'd5) begin
                    failures++; $display("[TB] FAIL fwd_data got=%h/%0d exp=cafe0001/5", m0_fwd_data, m0_fwd_dest);
                end
            end
            step();
        end
    endtask

    task automatic test_sram_wait();
        int          waits [3];
        logic [31:0] rd;
        logic [4:0]  d;
        waits[0] = 3;
        waits[1] = 1;
        waits[2] = $urandom_range(0, 5);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d  = 5'($urandom_range(1, 31));
            rd = $urandom;
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = make_bus(1'b1, 3'd5, 1'b1, d, $urandom, 32'h300);
            step();
            es_to_ms_valid = 1'b0;
            for (int k = 0; k < waits[i]; k++) begin
                @(negedge clk);
                checks++; if (m1_to_ws_valid !== 1'b0 || m1_fwd_ready !== 1'b0 || m1_fwd_valid !== 1'b1) begin
                    failures++; $display("[TB] FAIL wait[%0d][%0d] valid/fready/fvalid got=%b%b%b exp=001", i, k, m1_to_ws_valid, m1_fwd_ready, m1_fwd_valid);
                end
                step();
            end
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = rd;
            @(negedge clk);
            checks++; if (m1_to_ws_valid !== 1'b1 || m1_fwd_ready !== 1'b1) begin
                failures++; $display("[TB] FAIL wait_done[%0d] valid/fready got=%b%b exp=11", i, m1_to_ws_valid, m1_fwd_ready);
            end
            checks++; if (m1_to_ws_bus[63:32] !== rd) begin failures++; $display("[TB] FAIL wait_data[%0d] got=%h exp=%h", i, m1_to_ws_bus[63:32], rd); end
            step();
            data_sram_data_ok = 1'b0;
            @(negedge clk);
            checks++; if (m1_to_ws_valid !== 1'b0 || m1_allowin !== 1'b1) begin
                failures++; $display("[TB] FAIL wait_leave[%0d] valid/allowin got=%b%b exp=01", i, m1_to_ws_valid, m1_allowin);
            end
        end
    endtask

    task automatic test_resp_buf();
        do_reset();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(1'b1, 3'd5, 1'b1, 5'd7, 32'h400, 32'h404);
        step();
        es_to_ms_valid    = 1'b0;
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h1111_2222;
        @(negedge clk);
        checks++; if (m1_to_ws_valid !== 1'b1 || m1_allowin !== 1'b0) begin
            failures++; $display("[TB] FAIL buf_accept valid/allowin got=%b%b exp=10", m1_to_ws_valid, m1_allowin);
        end
        step();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'hEEEE_DDDD;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (m1_to_ws_valid !== 1'b1 || m1_to_ws_bus[63:32] !== 32'h1111_2222) begin
                failures++; $display("[TB] FAIL buf_hold[%0d] valid=%b data=%h exp 1/11112222", k, m1_to_ws_valid, m1_to_ws_bus[63:32]);
            end
            step();
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        checks++; if (m1_to_ws_valid !== 1'b1 || m1_to_ws_bus[63:32] !== 32'h1111_2222 || m1_allowin !== 1'b1) begin
            failures++; $display("[TB] FAIL buf_release valid=%b data=%h allowin=%b exp 1/11112222/1", m1_to_ws_valid, m1_to_ws_bus[63:32], m1_allowin);
        end
        step();
        @(negedge clk);
        checks++; if (m1_to_ws_valid !== 1'b0) begin failures++; $display("[TB] FAIL buf_gone got=%b exp=0", m1_to_ws_valid); end
    endtask

    task automatic test_flush_discard();
        logic [31:0] rd;
        // flush and entry in the same cycle drops the entering instruction
        do_reset();
        es_to_ms_valid = 1'b1;
        flush          = 1'b1;
        es_to_ms_bus   = make_bus(1'b0, 3'd0, 1'b1, 5'd5, 32'h55, 32'h500);
        step();
        es_to_ms_valid = 1'b0;
        flush          = 1'b0;
        @(negedge clk);
        checks++; if (m0_to_ws_valid !== 1'b0 || m0_fwd_valid !== 1'b0 || m0_allowin !== 1'b1) begin
            failures++; $display("[TB] FAIL flush_entry valid/fvalid/allowin got=%b%b%b exp=001", m0_to_ws_valid, m0_fwd_valid, m0_allowin);
        end

        do_reset();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(1'b1, 3'd5, 1'b1, 5'd9, 32'h600, 32'h600);
        step();
        es_to_ms_valid = 1'b0;
        step();
        flush = 1'b1;
        @(negedge clk);
        checks++; if (m1_to_ws_valid !== 1'b0) begin failures++; $display("[TB] FAIL flush_kill got=%b exp=0", m1_to_ws_valid); end
        step();
        flush = 1'b0;
        @(negedge clk);
        checks++; if (m1_allowin !== 1'b1 || m1_fwd_valid !== 1'b0) begin
            failures++; $display("[TB] FAIL flush_cleared allowin/fvalid got=%b%b exp=10", m1_allowin, m1_fwd_valid);
        end
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(1'b1, 3'd5, 1'b1, 5'd10, 32'h700, 32'h700);
        step();
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hAAAA_AAAA;
        @(negedge clk);
        checks++; if (m1_to_ws_valid !== 1'b0) begin failures++; $display("[TB] FAIL discard_first got=%b exp=0", m1_to_ws_valid); end
        step();
        data_sram_rdata = 32'hBBBB_0001;
        @(negedge clk);
        checks++; if (m1_to_ws_valid !== 1'b1 || m1_to_ws_bus[63:32] !== 32'hBBBB_0001) begin
            failures++; $display("[TB] FAIL discard_second valid=%b data=%h exp 1/bbbb0001", m1_to_ws_valid, m1_to_ws_bus[63:32]);
        end
        step();
        data_sram_data_ok = 1'b0;

        // four flushed requests saturate a 2-bit counter at 3
        do_reset();
        for (int i = 0; i < 4; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = make_bus(1'b1, 3'd5, 1'b1, 5'd3, 32'h800, 32'h800);
            step();
            es_to_ms_valid = 1'b0;
            flush          = 1'b1;
            step();
            flush = 1'b0;
        end
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = make_bus(1'b1, 3'd5, 1'b1, 5'd4, 32'h900, 32'h900);
        step();
        es_to_ms_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = $urandom;
            @(negedge clk);
            checks++; if (m1_to_ws_valid !== 1'b0) begin failures++; $display("[TB] FAIL sat_discard[%0d] got=%b exp=0", k, m1_to_ws_valid); end
            step();
        end
        rd              = $urandom;
        data_sram_rdata = rd;
        @(negedge clk);
        checks++; if (m1_to_ws_valid !== 1'b1 || m1_to_ws_bus[63:32] !== rd) begin
            failures++; $display("[TB] FAIL sat_complete valid=%b data=%h exp 1/%h", m1_to_ws_valid, m1_to_ws_bus[63:32], rd);
        end
        step();
        data_sram_data_ok = 1'b0;
    endtask

    // Random stream through the handshake instance against an occupancy model.
    task automatic test_back_to_back();
        logic        have, got, ready, exp_valid, exp_allow, exp_fv, exp_fr;
        logic [31:0] buf_val, exp_final;
        logic        c_hr, c_we;
        logic [2:0]  c_op;
        logic [4:0]  c_d;
        logic [31:0] c_alu, c_pc;
        logic        n_hr, n_we;
        logic [2:0]  n_op;
        logic [4:0]  n_d;
        logic [31:0] n_alu, n_pc;
        do_reset();
        have = 1'b0; got = 1'b0; buf_val = '0;
        c_hr = 1'b0; c_we = 1'b0; c_op = '0; c_d = '0; c_alu = '0; c_pc = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            n_op  = 3'($urandom_range(0, 7));
            n_hr  = ref_is_load(n_op) ? 1'b1 : 1'($urandom_range(0, 1));
            n_we  = 1'($urandom_range(0, 1));
            n_d   = 5'($urandom_range(0, 31));
            n_alu = $urandom;
            n_pc  = $urandom;
            es_to_ms_valid    = 1'($urandom_range(0, 1));
            es_to_ms_bus      = make_bus(n_hr, n_op, n_we, n_d, n_alu, n_pc);
            ws_allowin        = ($urandom_range(0, 3) != 0);
            data_sram_data_ok = (have && c_hr && !got) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_sram_rdata   = $urandom;
            @(negedge clk);
            ready     = !c_hr || got || data_sram_data_ok;
            exp_valid = have && ready;
            exp_allow = !have || (ready && ws_allowin);
            exp_final = ref_final(c_op, c_alu, got ? buf_val : data_sram_rdata);
            exp_fv    = have && c_we && (c_d != 5'd0);
            exp_fr    = exp_fv && (!ref_is_load(c_op) || ready);
            checks++; if (m1_to_ws_valid !== exp_valid) begin failures++; $display("[TB] FAIL b2b_valid[%0d] got=%b exp=%b", cyc, m1_to_ws_valid, exp_valid); end
            checks++; if (m1_allowin !== exp_allow) begin failures++; $display("[TB] FAIL b2b_allowin[%0d] got=%b exp=%b", cyc, m1_allowin, exp_allow); end
            checks++; if (m1_fwd_valid !== exp_fv || m1_fwd_ready !== exp_fr) begin
                failures++; $display("[TB] FAIL b2b_fwd[%0d] got=%b%b exp=%b%b", cyc, m1_fwd_valid, m1_fwd_ready, exp_fv, exp_fr);
            end
            if (exp_valid) begin
                checks++; if (m1_to_ws_bus !== {c_we, c_d, exp_final, c_pc}) begin
                    failures++; $display("[TB] FAIL b2b_bus[%0d] got=%h exp=%h", cyc, m1_to_ws_bus, {c_we, c_d, exp_final, c_pc});
                end
            end
            if (exp_fv) begin
                checks++; if (m1_fwd_data !== exp_final) begin failures++; $display("[TB] FAIL b2b_fwd_data[%0d] got=%h exp=%h", cyc, m1_fwd_data, exp_final); end
            end
            if (have && ready && ws_allowin) begin
                have = 1'b0;
                got  = 1'b0;
            end else if (have && data_sram_data_ok && !got) begin
                got     = 1'b1;
                buf_val = data_sram_rdata;
            end
            if (exp_allow && es_to_ms_valid) begin
                have = 1'b1; got = 1'b0;
                c_hr = n_hr; c_op = n_op; c_we = n_we; c_d = n_d; c_alu = n_alu; c_pc = n_pc;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_load_align();
        test_forwarding();
        test_sram_wait();
        test_resp_buf();
        test_flush_discard();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage_ls.md
MEM_STAGE_LS -- requirements
Module: mem_stage_ls

Interface
REQ-001 SHALL take parameter SRAM_MODE, default 0; 0 = fixed 1-cycle synchronous SRAM (rdata valid the cycle after the request), 1 = variable-latency handshake (rdata valid when data_ok is high).
REQ-002 SHALL take parameter DISCARD_W, default 2; width of the discard counter for flushed outstanding requests.
REQ-003 SHALL take parameter FWD_EN, default 1; 1 = forwarding port driven, 0 = forwarding outputs tied to 0.
REQ-004 Ports (name, direction, width, meaning), in order:
- clk, in, 1, clock.
- reset, in, 1, synchronous, active-high.
- flush, in, 1, kill the instruction held in MS.
- ws_allowin, in, 1, WB stage can accept.
- ms_allowin, out, 1, MS can accept.
- es_to_ms_valid, in, 1, EX stage presents an instruction.
- es_to_ms_bus, in, 74, fields {has_req[73], load_op[72:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}.
- ms_to_ws_valid, out, 1, result presented to WB.
- ms_to_ws_bus, out, 70, fields {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}.
- data_sram_data_ok, in, 1, read/write response (SRAM_MODE=1 only).
- data_sram_rdata, in, 32, read data.
- ms_fwd_valid, out, 1, MS holds a valid register-writing instruction.
- ms_fwd_dest, out, 5, its destination register.
- ms_fwd_ready, out, 1, its result is final.
- ms_fwd_data, out, 32, its result.

Function
REQ-005 load_op encoding SHALL be: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW; codes 6-7 behave as 0.
REQ-006 Byte lane SHALL be selected by alu_result[1:0]; LB/LBU SHALL select byte [8*a+7:8*a]; LH/LHU SHALL select the half at a[1]; LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend.
REQ-007 final_result SHALL be the aligned load data when load_op is nonzero, otherwise alu_result.
REQ-008 ms_ready_go SHALL be 1 when has_req=0.
REQ-009 When has_req=1, ms_ready_go SHALL be 1 if SRAM_MODE=0, else (data_ok accepted this cycle) OR resp_buf_valid.
REQ-010 ms_allowin SHALL equal !ms_valid || (ms_ready_go && ws_allowin).
REQ-011 ms_to_ws_valid SHALL equal ms_valid && ms_ready_go && !flush.
REQ-012 On es_to_ms_valid && ms_allowin, the bus SHALL be latched and ms_valid set the next cycle.
REQ-013 If ms_allowin && !es_to_ms_valid, ms_valid SHALL clear.
REQ-014 Response buffer (SRAM_MODE=1): data_ok accepted while ms_ready_go && !ws_allowin SHALL capture rdata into resp_buf and set resp_buf_valid.
REQ-015 The stage SHALL source final data from resp_buf while resp_buf_valid=1; resp_buf_valid SHALL clear when the instruction leaves MS.
REQ-016 flush SHALL clear ms_valid and resp_buf_valid at the next edge.
REQ-017 If flush hits a has_req instruction whose data_ok has not arrived, discard_cnt SHALL increment by 1.
REQ-018 While discard_cnt>0, each data_ok SHALL decrement discard_cnt by 1 and SHALL NOT be accepted by the current instruction.
REQ-019 discard_cnt SHALL saturate at 2^DISCARD_W-1.
REQ-020 Flush and a new es_to_ms_valid in the same cycle: ms_valid SHALL end 0; the new instruction is dropped.
REQ-021 Forwarding: ms_fwd_valid SHALL equal ms_valid && gr_we && dest!=0.
REQ-022 ms_fwd_ready SHALL equal ms_fwd_valid && (load_op==0 || ms_ready_go).
REQ-023 ms_fwd_data SHALL equal final_result.
REQ-024 All outputs SHALL be combinational from registered state plus same-cycle inputs; the stage SHALL add zero cycles beyond the response wait.

Reset
REQ-025 Reset SHALL clear ms_valid, resp_buf_valid and discard_cnt; all outputs derived from them SHALL read 0.
REQ-026 ms_allowin SHALL read 1 after reset.
REQ-027 The latched bus and resp_buf data SHALL NOT be reset.
REQ-028 Reset SHALL take priority over flush and over any handshake in the same cycle.

Structure
REQ-029 A shared package SHALL hold the bus widths (74/70), the bus field offsets and the load_op encodings.
REQ-030 Byte/half extraction and extension SHALL be one combinational sub-module, load_align (in: load_op, addr[1:0], rdata; out: 32-bit data).

Verification
REQ-031 SRAM_MODE=0, LB at addr 0x...3, rdata=0x80FF_1234 -> final_result=0xFFFF_FF80, ms_to_ws_valid for exactly 1 cycle.
REQ-032 LHU at addr[1]=1, rdata=0xBEEF_0000 -> 0x0000_BEEF; LH with the same inputs -> 0xFFFF_BEEF.
REQ-033 SRAM_MODE=1, LW, data_ok 3 cycles after entry -> ms_ready_go=0 and ms_fwd_ready=0 for 3 cycles, then the result passes with rdata.
REQ-034 SRAM_MODE=1, data_ok=1 with rdata=0x1111_2222 while ws_allowin=0 for 2 cycles -> resp_buf holds the value and WB receives 0x1111_2222 when ws_allowin rises.
REQ-035 Flush a pending LW, then enter a new LW -> the first data_ok is discarded (discard_cnt 1->0) and the second data_ok completes the new LW.
REQ-036 Non-load ADD to dest 0 vs dest 5 -> ms_fwd_valid=0 and ms_fwd_valid=ms_fwd_ready=1 respectively, with ms_fwd_data=alu_result.
